// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master issues requests and observes results; the slave is the adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice with a registered carry,
// LSB-first, producing {cout, sum} = a + b + cin with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] psum_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             s_s;
    logic             carry_next_s;
    logic             last_s;
    logic [WIDTH-1:0] psum_next_s;

    // Full-adder slice on the current LSBs and the partial sum with the new bit inserted at its MSB.
    always_comb begin
        s_s                      = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
        carry_next_s             = (a_sh_r[0] & b_sh_r[0]) | (carry_r & (a_sh_r[0] ^ b_sh_r[0]));
        psum_next_s              = psum_r >> 1'd1;
        psum_next_s[WIDTH-1]     = s_s;
        last_s                   = (cnt_r == CW'(WIDTH - 1));
    end

    // Control FSM and datapath; sum/cout only update on the transition into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            psum_r  <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        carry_r <= bus.cin;
                        cnt_r   <= '0;
                        psum_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ADD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    carry_r <= carry_next_s;
                    psum_r  <= psum_next_s;
                    a_sh_r  <= a_sh_r >> 1'd1;
                    b_sh_r  <= b_sh_r >> 1'd1;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum_r   <= psum_next_s;
                        cout_r  <= carry_next_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= ADD;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back random checks of serial_adder at WIDTH 8, 1 and 16.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(1))  if1  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int w, input logic st, input logic [63:0] av, input logic [63:0] bv,
                          input logic cv);
        case (w)
            1: begin
                if1.start = st; if1.a = av[0:0]; if1.b = bv[0:0]; if1.cin = cv;
            end
            16: begin
                if16.start = st; if16.a = av[15:0]; if16.b = bv[15:0]; if16.cin = cv;
            end
            default: begin
                if8.start = st; if8.a = av[7:0]; if8.b = bv[7:0]; if8.cin = cv;
            end
        endcase
    endtask

    task automatic get_out(input int w, output logic bsy, output logic dn, output logic [63:0] res);
        case (w)
            1: begin
                bsy = if1.busy; dn = if1.done; res = 64'({if1.cout, if1.sum});
            end
            16: begin
                bsy = if16.busy; dn = if16.done; res = 64'({if16.cout, if16.sum});
            end
            default: begin
                bsy = if8.busy; dn = if8.done; res = 64'({if8.cout, if8.sum});
            end
        endcase
    endtask

    // One directed WIDTH=8 operation from IDLE, checking latency, hold and result.
    task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic [8:0] exp);
        logic [8:0] prev;
        int         lat;
        bit         hold_ok;
        prev      = {if8.cout, if8.sum};
        if8.start = 1'b1; if8.a = av; if8.b = bv; if8.cin = cv;
        tick();
        if8.start = 1'b0; if8.a = ~av; if8.b = 8'h5A; if8.cin = ~cv;
        lat     = 0;
        hold_ok = 1'b1;
        while (!if8.done && lat < 40) begin
            if (!if8.busy || ({if8.cout, if8.sum} !== prev)) hold_ok = 1'b0;
            tick();
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'd8);
        check_val({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check_val({tag, "_res"}, 64'({if8.cout, if8.sum}), 64'(exp));
        check_val({tag, "_busy_at_done"}, 64'(if8.busy), 64'd0);
        tick();
        check_val({tag, "_done_pulse"}, 64'(if8.done), 64'd0);
    endtask

    // start tied high with fresh random operands every cycle; accepts land every w+2 edges.
    task automatic b2b(input int w, input int nops);
        logic [63:0] q[$];
        logic [63:0] ra, rb, mask, res, expv;
        logic        rc, bsy, dn;
        int          p;
        mask = (64'd1 << w) - 64'd1;
        for (int cyc = 0; cyc < nops * (w + 2); cyc++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(1, 0));
            set_in(w, 1'b1, ra, rb, rc);
            p = cyc % (w + 2);
            if (p == 0) q.push_back((ra & mask) + (rb & mask) + 64'(rc));
            tick();
            get_out(w, bsy, dn, res);
            check_val($sformatf("b2b%0d_done", w), 64'(dn), 64'(p == w));
            check_val($sformatf("b2b%0d_busy", w), 64'(bsy), 64'(p < w));
            if (dn) begin
                expv = (q.size() > 0) ? q.pop_front() : 64'hDEAD;
                check_val($sformatf("b2b%0d_res", w), res, expv);
            end
        end
        set_in(w, 1'b0, 64'd0, 64'd0, 1'b0);
        tick();
    endtask

    initial begin
        int  lat;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
        set_in(1, 1'b0, 64'd0, 64'd0, 1'b0);
        set_in(16, 1'b0, 64'd0, 64'd0, 1'b0);
        tick();
        tick();
        check_val("rst_busy", 64'(if8.busy), 64'd0);
        check_val("rst_done", 64'(if8.done), 64'd0);
        check_val("rst_res", 64'({if8.cout, if8.sum}), 64'd0);
        rst_n = 1'b1;

        run_op8("basic", 8'h35, 8'h4A, 1'b0, 9'h07F);
        run_op8("ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_op8("maxcin", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        run_op8("zerocin", 8'h00, 8'h00, 1'b1, 9'h001);

        // Second request held during ADD/DONE must wait for the edge after DONE.
        if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
        tick();
        if8.a = 8'hAA; if8.b = 8'h55;
        lat = 0;
        while (!if8.done && lat < 40) begin
            tick();
            lat++;
        end
        check_val("ign_lat", 64'(lat), 64'd8);
        check_val("ign_res1", 64'({if8.cout, if8.sum}), 64'h030);
        tick();
        check_val("ign_idle_busy", 64'(if8.busy), 64'd0);
        check_val("ign_idle_res", 64'({if8.cout, if8.sum}), 64'h030);
        tick();
        check_val("ign_accept", 64'(if8.busy), 64'd1);
        if8.start = 1'b0;
        lat = 0;
        while (!if8.done && lat < 40) begin
            tick();
            lat++;
        end
        check_val("ign_lat2", 64'(lat), 64'd8);
        check_val("ign_res2", 64'({if8.cout, if8.sum}), 64'h0FF);
        tick();

        // Asynchronous reset in the middle of an operation.
        if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (4) tick();
        check_val("mid_busy_pre", 64'(if8.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_busy", 64'(if8.busy), 64'd0);
        check_val("mid_done", 64'(if8.done), 64'd0);
        check_val("mid_res", 64'({if8.cout, if8.sum}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        lat = 0;
        repeat (6) begin
            tick();
            if (if8.done || if8.busy) lat++;
        end
        check_val("mid_no_done", 64'(lat), 64'd0);
        run_op8("after_rst", 8'h80, 8'h80, 1'b0, 9'h100);

        b2b(8, 200);
        b2b(1, 200);
        b2b(16, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a one-bit full-adder slice and a registered carry. It is the additive counterpart to the team's full subtractor datapath. Operands are captured on a start request and processed LSB-first, one bit per clock. A complete sum and carry-out are presented with a one-cycle done pulse. It serves area-constrained arithmetic paths where one result per WIDTH+2 cycles is sufficient.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32

- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      operation request; sampled only in IDLE
- a      input   WIDTH  addend A; sampled on the accepting edge only
- b      input   WIDTH  addend B; sampled on the accepting edge only
- cin    input   1      carry-in; sampled on the accepting edge only
- busy   output  1      high while bits are being processed
- done   output  1      one-cycle pulse; sum/cout valid and newly updated
- sum    output  WIDTH  registered result, held until the next completion
- cout   output  1      registered carry-out, held until the next completion

## Operation
- Result: {cout, sum} = a + b + cin, exact, (WIDTH+1)-bit, no overflow loss.
- States: IDLE, ADD, DONE; reset state IDLE.
- IDLE, start=1: load the A/B shift registers from a/b, load the carry register from cin, clear the bit counter, clear the internal partial-sum register; go to ADD.
- IDLE, start=0: stay in IDLE.
- ADD, each cycle:
  - s = a0 ^ b0 ^ c.
  - c <= (a0 & b0) | (c & (a0 ^ b0)).
  - Shift the partial sum right with s into its MSB.
  - Shift A and B right.
  - Increment the counter.
- ADD, on the cycle processing bit WIDTH-1:
  - Go to DONE.
  - Load sum from the final partial sum, including the bit s computed that cycle.
  - Load cout from the final carry.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in ADD and DONE; requests are never queued.
- a, b and cin may change freely after the accepting edge without affecting the result.
- sum and cout are unchanged during ADD and hold the previous result. They change only on entry to DONE.
- WIDTH=1 degenerates to one ADD cycle.

## Timing
- Reset (rst_n low, asynchronous, any state):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry and counter are cleared.
  - An in-flight operation is abandoned with no done pulse.
- Release of reset is synchronous to clk; the first start is accepted on the first rising edge with rst_n high.
- Let E0 be the edge that samples start=1 in IDLE:
  - busy rises after E0.
  - Edges E1..EWIDTH each process one bit.
  - After EWIDTH: busy=0, done=1, sum/cout valid.
  - After EWIDTH+1: done=0, state IDLE.
  - Earliest next accepting edge is EWIDTH+2.
- Latency from the accepting edge to done: WIDTH edges. With start held high continuously, one result is produced every WIDTH+2 cycles.
- busy and done are never high in the same cycle. All outputs are registered, with no combinational input-to-output path.

## Test plan
- Basic add: WIDTH=8, a=8'h35, b=8'h4A, cin=0, one-cycle start -> busy high for 8 cycles; done pulses 8 edges after acceptance; sum=8'h7F, cout=0.
- Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- Max with carry-in: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=0, b=0, cin=1 -> sum=8'h01, cout=0.
- Ignore start while busy:
  - Accept a=8'h10, b=8'h20.
  - Then drive start=1 with a=8'hAA, b=8'h55 during ADD and DONE.
  - Result 8'h30 is delivered with sum held at its prior value until done.
  - The second operation is accepted at EWIDTH+2 and yields sum=8'hFF, cout=0.
- Reset mid-operation:
  - Assert rst_n=0 at bit 4 of an operation -> busy, done, sum and cout go to 0 immediately; no done pulse.
  - After release, a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
- Back-to-back plus random: start tied high over 200 random operand/cin sets -> done exactly every 10 cycles; every {cout,sum} matches a+b+cin. Repeat with WIDTH=1 and WIDTH=16.
